// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of the shared data memory.
// Round-robin between core and loader, with a bounded grant lock.
module dmem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              lock0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [31:0]       wdata0,
    input  logic              req1,
    input  logic              lock1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata1,
    output logic              ack0,
    output logic [31:0]       rdata0,
    output logic              rvld0,
    output logic              ack1,
    output logic [31:0]       rdata1,
    output logic              rvld1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE0,
        SERVE1
    } state_e;

    localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata0_q, rdata0_d;
    logic [31:0]       rdata1_q, rdata1_d;
    logic              rvld0_q, rvld0_d;
    logic              rvld1_q, rvld1_d;
    logic              hold0, hold1;

    // Memory port mux: the granted requester drives the memory this cycle.
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_we    = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        unique case (state_q)
            SERVE0: begin
                mem_addr  = addr0;
                mem_wdata = wdata0;
                mem_we    = we0 & req0;
                ack0      = req0;
            end
            SERVE1: begin
                mem_addr  = addr1;
                mem_wdata = wdata1;
                mem_we    = we1 & req1;
                ack1      = req1;
            end
            default: ;
        endcase
    end

    // Arbitration: lock hold wins, else round-robin on the updated pointer.
    always_comb begin
        last_d = last_q;
        if (ack0) begin
            last_d = 1'b0;
        end else if (ack1) begin
            last_d = 1'b1;
        end
        hold0 = (state_q == SERVE0) && lock0 && req0
                && (cnt_q < LOCK_MAX);
        hold1 = (state_q == SERVE1) && lock1 && req1
                && (cnt_q < LOCK_MAX);
        state_d = IDLE;
        if (hold0) begin
            state_d = SERVE0;
        end else if (hold1) begin
            state_d = SERVE1;
        end else if (req0 && req1) begin
            state_d = last_d ? SERVE0 : SERVE1;
        end else if (req0) begin
            state_d = SERVE0;
        end else if (req1) begin
            state_d = SERVE1;
        end
        cnt_d = 8'd0;
        if (state_d != IDLE) begin
            if (state_d != state_q) begin
                cnt_d = 8'd1;
            end else if (cnt_q < LOCK_MAX) begin
                cnt_d = cnt_q + 8'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (ack0 || ack1) begin
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
        end
    end

    // Read return: capture memory data only for acked reads.
    always_comb begin
        rvld0_d  = ack0 & ~we0;
        rvld1_d  = ack1 & ~we1;
        rdata0_d = rvld0_d ? mem_rdata : rdata0_q;
        rdata1_d = rvld1_d ? mem_rdata : rdata1_q;
    end

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            cnt_q    <= 8'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            rvld0_q  <= 1'b0;
            rvld1_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            rvld0_q  <= rvld0_d;
            rvld1_q  <= rvld1_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;
    assign rvld0  = rvld0_q;
    assign rvld1  = rvld1_q;

endmodule
